// File: rtl/button_event_decoder.sv
// button_event_decoder
// Turns a debounced, clock-synchronous button level into single-cycle gesture
// pulses: press, release, single click, double click and long press.
// Optional feature macro: BTN_AUTO_REPEAT_EN adds periodic repeat pulses while
// a long press is held; without it repeat_pulse is tied low.
module button_event_decoder #(
    parameter int CLK_PERIOD_NS = 20,
    parameter int LONG_PRESS_MS = 1000,
    parameter int DOUBLE_GAP_MS = 300,
    parameter int REPEAT_MS     = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic btn_held
);

    // 64-bit intermediate so large ms values do not overflow before division
    localparam longint NS_PER_MS  = 64'd1_000_000;
    localparam int     LONG_CNT   = int'(longint'(LONG_PRESS_MS) * NS_PER_MS / longint'(CLK_PERIOD_NS));
    localparam int     GAP_CNT    = int'(longint'(DOUBLE_GAP_MS) * NS_PER_MS / longint'(CLK_PERIOD_NS));
    localparam int     REPEAT_CNT = int'(longint'(REPEAT_MS)     * NS_PER_MS / longint'(CLK_PERIOD_NS));
    localparam int     MAX_LG     = (LONG_CNT > GAP_CNT) ? LONG_CNT : GAP_CNT;
    localparam int     MAX_CNT    = (MAX_LG > REPEAT_CNT) ? MAX_LG : REPEAT_CNT;
    localparam int     CW         = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

    typedef enum logic [2:0] {IDLE, PRESS1, GAP, PRESS2, LONG} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            btn_dly_q, btn_dly_d;   // previous-cycle btn_level
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            click_q, click_d;
    logic            double_q, double_d;
    logic            long_q, long_d;
    logic            held_q, held_d;
    logic            rise, fall, long_hit, gap_hit;

    assign rise     = btn_level & ~btn_dly_q;
    assign fall     = ~btn_level & btn_dly_q;
    assign long_hit = (cnt_q == CW'(LONG_CNT - 1));
    assign gap_hit  = (cnt_q == CW'(GAP_CNT - 1));

    // Next-state and pulse decode; an input edge always wins over counter expiry
    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        double_d  = 1'b0;
        long_d    = 1'b0;
        unique case (state_q)
            IDLE: if (rise) begin
                state_d = PRESS1;
                press_d = 1'b1;
            end
            PRESS1: if (fall) begin
                state_d   = GAP;
                release_d = 1'b1;
            end else if (long_hit) begin
                state_d = LONG;
                long_d  = 1'b1;
            end
            GAP: if (rise) begin
                state_d = PRESS2;
                press_d = 1'b1;
            end else if (gap_hit) begin
                state_d = IDLE;
                click_d = 1'b1;
            end
            PRESS2: if (fall) begin
                state_d   = IDLE;
                release_d = 1'b1;
                double_d  = 1'b1;
            end else if (long_hit) begin
                state_d = LONG;
                long_d  = 1'b1;
            end
            LONG: if (fall) begin
                state_d   = IDLE;
                release_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        held_d    = (state_d == PRESS1) || (state_d == PRESS2) || (state_d == LONG);
        btn_dly_d = btn_level;
        // shared timer: restart on any state change, otherwise count and saturate
        if (state_d != state_q)  cnt_d = '0;
        else if (cnt_q != '1)    cnt_d = cnt_q + CW'(1);
        else                     cnt_d = cnt_q;
    end

    // State, timer, edge-detect and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            btn_dly_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            btn_dly_q <= btn_dly_d;
            press_q   <= press_d;
            release_q <= release_d;
            click_q   <= click_d;
            double_q  <= double_d;
            long_q    <= long_d;
            held_q    <= held_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign click_pulse   = click_q;
    assign double_pulse  = double_q;
    assign long_pulse    = long_q;
    assign btn_held      = held_q;

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RW = (REPEAT_CNT > 2) ? $clog2(REPEAT_CNT) : 1;

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          repeat_q, repeat_d;

    // Repeat timer runs only while staying in LONG; a release edge suppresses it
    always_comb begin
        rcnt_d   = '0;
        repeat_d = 1'b0;
        if (state_q == LONG && !fall) begin
            if (rcnt_q == RW'(REPEAT_CNT - 1)) begin
                repeat_d = 1'b1;
                rcnt_d   = '0;
            end else begin
                rcnt_d   = rcnt_q + RW'(1);
            end
        end
    end

    // Repeat timer and pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt_q   <= '0;
            repeat_q <= 1'b0;
        end else begin
            rcnt_q   <= rcnt_d;
            repeat_q <= repeat_d;
        end
    end

    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed gestures plus random level streams,
// checked cycle by cycle against a gesture-level reference model.
module tb_button_event_decoder;
    localparam int LONG = 10;
    localparam int GAPC = 4;
    localparam int REP  = 3;
    localparam int MAXN = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_level = 1'b0;
    logic press_pulse, release_pulse, click_pulse, double_pulse;
    logic long_pulse, repeat_pulse, btn_held;

    int tests = 0;
    int fails = 0;

    bit       lv[$];
    bit [6:0] ex[MAXN];   // 0 press,1 release,2 click,3 double,4 long,5 repeat,6 held
    string    names[7] = '{"press", "release", "click", "double", "long", "repeat", "held"};

    button_event_decoder #(
        .CLK_PERIOD_NS(1_000_000),
        .LONG_PRESS_MS(10),
        .DOUBLE_GAP_MS(4),
        .REPEAT_MS(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .click_pulse(click_pulse),
        .double_pulse(double_pulse),
        .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse),
        .btn_held(btn_held)
    );

    always #5 clk = ~clk;

    function automatic bit [6:0] outs();
        return {btn_held, repeat_pulse, long_pulse, double_pulse,
                click_pulse, release_pulse, press_pulse};
    endfunction

    task automatic check(string tag, int cyc, logic got, logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all(string ctx, int cyc, bit [6:0] exp);
        bit [6:0] g;
        g = outs();
        for (int b = 0; b < 7; b++) check({ctx, ".", names[b]}, cyc, g[b], exp[b]);
    endtask

    task automatic push(bit v, int len);
        repeat (len) lv.push_back(v);
    endtask

    function automatic int runlen(int s, bit v);
        int k = 0;
        while (s + k < lv.size() && lv[s + k] == v) k++;
        return k;
    endfunction

    function automatic void mark(int t, int b);
        if (t >= 0 && t < MAXN) ex[t][b] = 1'b1;
    endfunction

    function automatic void hold_marks(int p, int r);
        for (int k = p; k < r; k++) mark(k, 6);
    endfunction

    function automatic void long_gesture(int p, int r);
        hold_marks(p, r);
        mark(p + LONG, 4);
        mark(r, 1);
`ifdef BTN_AUTO_REPEAT_EN
        for (int k = p + LONG + REP; k < r; k += REP) mark(k, 5);
`endif
    endfunction

    // Gesture model: works on run lengths of the level stream. ex[t] is the
    // output expected right after the clock edge that samples lv[t].
    // Hold of exactly LONG cycles is still short; gap of exactly GAPC is a re-press.
    function automatic void build_model();
        int n, t, p, h, r, g;
        n = lv.size();
        t = 0;
        for (int i = 0; i < MAXN; i++) ex[i] = '0;
        while (t < n) begin
            if (!lv[t]) begin t++; continue; end
            p = t; mark(p, 0);
            h = runlen(p, 1'b1); r = p + h;
            if (h > LONG) begin long_gesture(p, r); t = r; continue; end
            hold_marks(p, r); mark(r, 1);
            g = runlen(r, 1'b0);
            if (g > GAPC) begin mark(r + GAPC, 2); t = r + g; continue; end
            p = r + g; mark(p, 0);
            h = runlen(p, 1'b1); r = p + h;
            if (h > LONG) long_gesture(p, r);
            else begin hold_marks(p, r); mark(r, 1); mark(r, 3); end
            t = r;
        end
    endfunction

    task automatic do_reset();
        btn_level = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic run_seq(string ctx);
        do_reset();
        build_model();
        for (int t = 0; t < lv.size(); t++) begin
            @(negedge clk) btn_level = lv[t];
            @(posedge clk);
            #1;
            check_all(ctx, t, ex[t]);
        end
        lv.delete();
    endtask

    initial begin
        int h, g;
        // reset state
        #1 rst = 1'b1;
        #1 check_all("reset", 0, 7'b0);
        do_reset();
        @(posedge clk); #1 check_all("post_reset_idle", 0, 7'b0);

        // single click
        push(0, 2); push(1, 3); push(0, 8);
        run_seq("click");
        // double click
        push(0, 2); push(1, 2); push(0, 2); push(1, 2); push(0, 8);
        run_seq("double");
        // long press
        push(0, 2); push(1, 15); push(0, 8);
        run_seq("long");
        // boundaries: release at hold 10 then click; release at 10, re-press at gap 4
        push(0, 2); push(1, LONG); push(0, 8);
        run_seq("bnd_click");
        push(0, 2); push(1, LONG); push(0, GAPC); push(1, 3); push(0, 8);
        run_seq("bnd_gap");
        push(0, 2); push(1, 2); push(0, GAPC + 1); push(1, 2); push(0, 8);
        run_seq("gap_plus1");
        // auto-repeat window
        push(0, 2); push(1, 20); push(0, 8);
        run_seq("repeat");
        push(0, 2); push(1, LONG + 2 * REP); push(0, 8);
        run_seq("repeat_fall");
        // second press turned long press
        push(0, 2); push(1, 3); push(0, 2); push(1, 14); push(0, 8);
        run_seq("press2_long");

        // randomized level streams
        for (int s = 0; s < 6; s++) begin
            push(0, 2);
            for (int i = 0; i < 14; i++) begin
                h = ($urandom_range(0, 4) == 0) ? LONG : int'($urandom_range(1, 18));
                g = ($urandom_range(0, 4) == 0) ? GAPC : int'($urandom_range(1, 7));
                push(1, h); push(0, g);
            end
            push(0, GAPC + 3);
            run_seq("random");
        end

        // reset mid-gesture: abort in GAP, then come out of reset with button held
        do_reset();
        repeat (3) begin @(negedge clk) btn_level = 1'b1; end
        @(negedge clk) btn_level = 1'b0;
        @(posedge clk); #1;
        check("rst_seq.release", 0, release_pulse, 1'b1);
        #1 rst = 1'b1;
        #1 check_all("rst_async", 0, 7'b0);
        @(negedge clk) btn_level = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1 check_all("rst_held", c, 7'b0);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("rst_rel.press", 0, press_pulse, 1'b1);
        check("rst_rel.held", 0, btn_held, 1'b1);
        @(posedge clk); #1;
        check("rst_rel.press_end", 1, press_pulse, 1'b0);
        @(negedge clk) btn_level = 1'b0;
        @(posedge clk); #1;
        check("rst_rel.release", 2, release_pulse, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
